pe_stream_pkt_arbiter: RTL and testbench
========================================

// Module: pe_stream_pkt_arbiter
// PURPOSE
//  Packet-atomic round-robin arbiter sharing the protocol-engine input stream register among NUM_PORTS
//  axis-like requesters (tstart/tlast/tkeep/tuser/tdata, valid/ready). Grants one requester at a time and holds the
//  grant from the tstart beat through the tlast beat. Drives the stream-register slave side; sits between source
//  engines and the PE input register.
// PARAMETERS
//  NUM_PORTS    4              number of requesters, 2..8
//  TUSER_WIDTH  128            per-beat sideband width
//  TDATA_WIDTH  256            per-beat data width
//  TKEEP_WIDTH  TDATA_WIDTH/8  byte-enable width
//  PID_WIDTH    $clog2(NUM_PORTS)  grant index width
// PORTS
//  clk          in   1                        clock
//  rst_n        in   1                        asynchronous active-low reset
//  s_tvalid     in   NUM_PORTS                per-requester valid
//  s_tstart     in   NUM_PORTS                per-requester first-beat flag
//  s_tlast      in   NUM_PORTS                per-requester last-beat flag
//  s_tkeep      in   NUM_PORTS*TKEEP_WIDTH    flattened; port i at [i*TKEEP_WIDTH +: TKEEP_WIDTH]
//  s_tuser      in   NUM_PORTS*TUSER_WIDTH    flattened, same packing
//  s_tdata      in   NUM_PORTS*TDATA_WIDTH    flattened, same packing
//  s_tready     out  NUM_PORTS                per-requester ready
//  m_tvalid     out  1                        to stream register
//  m_tstart     out  1
//  m_tlast      out  1
//  m_tkeep      out  TKEEP_WIDTH
//  m_tuser      out  TUSER_WIDTH
//  m_tdata      out  TDATA_WIDTH
//  m_tready     in   1                        from stream register
//  grant_id     out  PID_WIDTH                current/last granted port
//  busy         out  1                        1 while in LOCK
// BEHAVIOUR
//  - Reset: state=IDLE, rr_ptr=0, grant_id=0, busy=0, s_tready=0, m_tvalid=0.
//    All m_* payload outputs are 0 whenever m_tvalid=0.
//  - Eligible port i: s_tvalid[i]&s_tstart[i]. In IDLE, a port with valid but no tstart is never granted;
//    it is held (s_tready=0).
//  - IDLE: if any port is eligible, choose the first eligible at or after rr_ptr (circular).
//    Register grant_id=choice and go to LOCK. No beat is transferred in IDLE: 1-cycle arbitration bubble.
//  - LOCK: combinational mux of granted port g to m_*: m_tvalid=s_tvalid[g], s_tready[g]=m_tready,
//    and s_tready=0 for all other ports. A beat transfers when s_tvalid[g]&m_tready.
//  - LOCK exit: on a transferred beat with s_tlast[g]=1, go to IDLE with rr_ptr=(g+1) mod NUM_PORTS.
//    The next grant is therefore >=1 cycle later.
//  - Single-beat packet (tstart&tlast on the same beat): LOCK for exactly the transfer cycle(s), then IDLE.
//  - Granted source deasserts s_tvalid mid-packet: stay in LOCK with m_tvalid=0. No timeout, no preemption.
//  - A tstart seen in LOCK on a non-first beat is passed through unchanged; the arbiter does not check it.
//  - Backpressure: m_tready=0 holds m_* stable only if the granted source holds its own outputs stable.
//    The arbiter adds no storage.
//  - rst_n assertion mid-packet: immediate return to reset values. The partial packet is abandoned;
//    the downstream register is reset by the same rst_n.
//  - grant_id holds its last value in IDLE. busy = (state==LOCK).
// TESTING
//  1 Reset, all ports idle -> m_tvalid=0, s_tready=0, m_tdata=0, grant_id=0, busy=0.
//  2 Port 2 sends a 3-beat packet, m_tready=1 -> grant on cycle 1, beats out cycles 2-4 with data intact;
//    IDLE cycle 5; rr_ptr=3.
//  3 Ports 0,1,3 each hold a 2-beat packet, rr_ptr=0 -> grant order 0,1,3;
//    each packet contiguous with no interleaving; one idle bubble between packets.
//  4 Port 1 mid-packet, m_tready toggled 1,0,0,1 -> no beat lost or duplicated; s_tready[1] mirrors m_tready;
//    port 0 (valid) sees s_tready=0.
//  5 Port 0 valid with tstart=0 in IDLE -> never granted. Port 2 single-beat (tstart=tlast=1) ->
//    granted and completes in 1 transfer.
//  6 rst_n pulsed low during beat 2 of a 4-beat packet -> outputs 0 asynchronously;
//    after release, a new port-3 packet is granted normally.

Source files
------------

// File: rtl/pe_stream_pkt_arbiter.sv
// Packet-atomic round-robin arbiter in front of the protocol-engine input stream register.
// One requester owns the stream from its tstart beat through its tlast beat; no storage is added.
module pe_stream_pkt_arbiter #(
    parameter int NUM_PORTS   = 4,
    parameter int TUSER_WIDTH = 128,
    parameter int TDATA_WIDTH = 256,
    parameter int TKEEP_WIDTH = TDATA_WIDTH / 8,
    parameter int PID_WIDTH   = $clog2(NUM_PORTS)
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_PORTS-1:0]             s_tvalid,
    input  logic [NUM_PORTS-1:0]             s_tstart,
    input  logic [NUM_PORTS-1:0]             s_tlast,
    input  logic [NUM_PORTS*TKEEP_WIDTH-1:0] s_tkeep,
    input  logic [NUM_PORTS*TUSER_WIDTH-1:0] s_tuser,
    input  logic [NUM_PORTS*TDATA_WIDTH-1:0] s_tdata,
    output logic [NUM_PORTS-1:0]             s_tready,
    output logic                             m_tvalid,
    output logic                             m_tstart,
    output logic                             m_tlast,
    output logic [TKEEP_WIDTH-1:0]           m_tkeep,
    output logic [TUSER_WIDTH-1:0]           m_tuser,
    output logic [TDATA_WIDTH-1:0]           m_tdata,
    input  logic                             m_tready,
    output logic [PID_WIDTH-1:0]             grant_id,
    output logic                             busy
);

    // state | meaning
    // IDLE  | no owner; pick the next eligible requester (one-cycle bubble, no transfer)
    // LOCK  | grant_q owns the stream until its tlast beat transfers
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_LOCK = 1'b1;

    localparam logic [PID_WIDTH:0]   NP_EXT   = (PID_WIDTH+1)'(NUM_PORTS);
    localparam logic [PID_WIDTH-1:0] LAST_PID = PID_WIDTH'(NUM_PORTS - 1);

    logic [0:0]           state_q, state_d;
    logic [PID_WIDTH-1:0] grant_q, grant_d;
    logic [PID_WIDTH-1:0] rr_ptr_q, rr_ptr_d;

    logic [NUM_PORTS-1:0] eligible;
    logic                 pick_valid;
    logic [PID_WIDTH-1:0] pick_idx;
    logic [PID_WIDTH:0]   cand;

    logic                   lock;
    logic                   sel_valid;
    logic                   sel_start;
    logic                   sel_last;
    logic [TKEEP_WIDTH-1:0] sel_keep;
    logic [TUSER_WIDTH-1:0] sel_user;
    logic [TDATA_WIDTH-1:0] sel_data;
    logic                   pkt_done;
    logic [PID_WIDTH-1:0]   next_ptr;

    assign lock     = (state_q == ST_LOCK);
    assign eligible = s_tvalid & s_tstart;

    // Circular search starting at rr_ptr_q; first hit wins.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            cand = {1'b0, rr_ptr_q} + (PID_WIDTH+1)'(k);
            if (cand >= NP_EXT) begin
                cand = cand - NP_EXT;
            end
            if (!pick_valid && eligible[cand[PID_WIDTH-1:0]]) begin
                pick_valid = 1'b1;
                pick_idx   = cand[PID_WIDTH-1:0];
            end
        end
    end

    always_comb begin
        sel_valid = 1'b0;
        sel_start = 1'b0;
        sel_last  = 1'b0;
        sel_keep  = '0;
        sel_user  = '0;
        sel_data  = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (grant_q == PID_WIDTH'(i)) begin
                sel_valid = s_tvalid[i];
                sel_start = s_tstart[i];
                sel_last  = s_tlast[i];
                sel_keep  = s_tkeep[i*TKEEP_WIDTH +: TKEEP_WIDTH];
                sel_user  = s_tuser[i*TUSER_WIDTH +: TUSER_WIDTH];
                sel_data  = s_tdata[i*TDATA_WIDTH +: TDATA_WIDTH];
            end
        end
    end

    // Payload is forced to zero whenever no beat is being offered downstream.
    assign m_tvalid = lock & sel_valid;
    assign m_tstart = m_tvalid & sel_start;
    assign m_tlast  = m_tvalid & sel_last;
    assign m_tkeep  = m_tvalid ? sel_keep : '0;
    assign m_tuser  = m_tvalid ? sel_user : '0;
    assign m_tdata  = m_tvalid ? sel_data : '0;

    always_comb begin
        s_tready = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (lock && (grant_q == PID_WIDTH'(i))) begin
                s_tready[i] = m_tready;
            end
        end
    end

    assign pkt_done = m_tvalid & m_tready & sel_last;
    assign next_ptr = (grant_q == LAST_PID) ? '0 : grant_q + PID_WIDTH'(1);

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        if (state_q == ST_IDLE) begin
            if (pick_valid) begin
                state_d = ST_LOCK;
                grant_d = pick_idx;
            end
        end else begin
            if (pkt_done) begin
                state_d  = ST_IDLE;
                rr_ptr_d = next_ptr;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign grant_id = grant_q;
    assign busy     = lock;

endmodule

// File: tb/tb_pe_stream_pkt_arbiter.sv
// Self-checking bench for pe_stream_pkt_arbiter: packet-level sources and a round-robin
// ownership model derived from the arbitration rules, plus directed scenarios.
module tb_pe_stream_pkt_arbiter;

    localparam int NP = 4;
    localparam int TU = 128;
    localparam int TD = 256;
    localparam int TK = TD / 8;
    localparam int PW = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NP-1:0]     s_tvalid, s_tstart, s_tlast, s_tready;
    logic [NP*TK-1:0]  s_tkeep;
    logic [NP*TU-1:0]  s_tuser;
    logic [NP*TD-1:0]  s_tdata;
    logic              m_tvalid, m_tstart, m_tlast, m_tready;
    logic [TK-1:0]     m_tkeep;
    logic [TU-1:0]     m_tuser;
    logic [TD-1:0]     m_tdata;
    logic [PW-1:0]     grant_id;
    logic              busy;

    always #5 clk = ~clk;

    pe_stream_pkt_arbiter #(
        .NUM_PORTS(NP), .TUSER_WIDTH(TU), .TDATA_WIDTH(TD), .TKEEP_WIDTH(TK), .PID_WIDTH(PW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .s_tvalid(s_tvalid), .s_tstart(s_tstart), .s_tlast(s_tlast),
        .s_tkeep(s_tkeep), .s_tuser(s_tuser), .s_tdata(s_tdata), .s_tready(s_tready),
        .m_tvalid(m_tvalid), .m_tstart(m_tstart), .m_tlast(m_tlast),
        .m_tkeep(m_tkeep), .m_tuser(m_tuser), .m_tdata(m_tdata), .m_tready(m_tready),
        .grant_id(grant_id), .busy(busy)
    );

    typedef struct packed {
        logic          st;
        logic          la;
        logic [TK-1:0] k;
        logic [TU-1:0] u;
        logic [TD-1:0] d;
    } beat_t;

    beat_t srcq [NP][$];
    int    src_seq [NP];
    int    out_seq [NP];
    bit    nostart [NP];
    bit    hold_rand, tready_rand;
    bit    tready_q [$];

    // Ownership model: who holds the stream and where the round-robin search starts.
    bit    mdl_lock;
    int    mdl_gid, mdl_rr;

    int    checks, errors, fires, cyc;
    int    obs_starts [$];
    bit    busy_hist [$];
    int    fire_cyc [$];

    function automatic logic [TD-1:0] rand_data();
        logic [TD-1:0] v;
        for (int w = 0; w < TD/32; w++) v[w*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [TU-1:0] rand_user();
        logic [TU-1:0] v;
        for (int w = 0; w < TU/32; w++) v[w*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic int rr_pick(logic [NP-1:0] e, int rr);
        for (int k = 0; k < NP; k++) begin
            if (e[(rr + k) % NP]) return (rr + k) % NP;
        end
        return -1;
    endfunction

    function automatic bit pending();
        for (int i = 0; i < NP; i++) if (srcq[i].size() != 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic add_pkt(int p, int n);
        beat_t b;
        for (int j = 0; j < n; j++) begin
            b.d = rand_data();
            b.d[15:0]  = 16'(src_seq[p]);
            b.d[19:16] = 4'(p);
            b.u  = rand_user();
            b.k  = $urandom;
            b.st = (j == 0);
            b.la = (j == n - 1);
            srcq[p].push_back(b);
            src_seq[p]++;
        end
    endtask

    task automatic clear_logs();
        obs_starts.delete();
        busy_hist.delete();
        fire_cyc.delete();
        cyc   = 0;
        fires = 0;
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        s_tvalid = '0; s_tstart = '0; s_tlast = '0;
        s_tkeep  = '0; s_tuser  = '0; s_tdata = '0;
        m_tready = 1'b0;
        for (int i = 0; i < NP; i++) begin
            srcq[i].delete();
            src_seq[i] = 0;
            out_seq[i] = 0;
            nostart[i] = 1'b0;
        end
        hold_rand = 1'b0; tready_rand = 1'b0; tready_q.delete();
        mdl_lock = 1'b0; mdl_gid = 0; mdl_rr = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic drive_inputs();
        beat_t b;
        for (int i = 0; i < NP; i++) begin
            if (nostart[i]) begin
                s_tvalid[i] = 1'b1; s_tstart[i] = 1'b0; s_tlast[i] = 1'b0;
                s_tkeep[i*TK +: TK] = $urandom;
                s_tuser[i*TU +: TU] = rand_user();
                s_tdata[i*TD +: TD] = rand_data();
            end else if (srcq[i].size() != 0 && !(hold_rand && $urandom_range(0, 3) == 0)) begin
                b = srcq[i][0];
                s_tvalid[i] = 1'b1; s_tstart[i] = b.st; s_tlast[i] = b.la;
                s_tkeep[i*TK +: TK] = b.k;
                s_tuser[i*TU +: TU] = b.u;
                s_tdata[i*TD +: TD] = b.d;
            end else begin
                s_tvalid[i] = 1'b0; s_tstart[i] = 1'b0; s_tlast[i] = 1'b0;
                s_tkeep[i*TK +: TK] = '0;
                s_tuser[i*TU +: TU] = '0;
                s_tdata[i*TD +: TD] = '0;
            end
        end
        if (tready_q.size() != 0) m_tready = tready_q.pop_front();
        else if (tready_rand)     m_tready = ($urandom_range(0, 2) != 0);
        else                      m_tready = 1'b1;
    endtask

    // Compare DUT outputs against the ownership model; inputs are stable until the next negedge.
    task automatic evaluate();
        logic [NP-1:0] e;
        logic [NP-1:0] exp_rdy;
        int            g, p;
        busy_hist.push_back(busy);
        if (!mdl_lock) begin
            checks++;
            if (busy !== 1'b0 || m_tvalid !== 1'b0 || s_tready !== '0 || m_tdata !== '0)
                $display("FAIL idle_outputs: busy=%b m_tvalid=%b s_tready=%b, required 0/0/0", busy, m_tvalid, s_tready);
            checks++;
            if (grant_id !== PW'(mdl_gid))
                $display("FAIL grant_hold: grant_id=%0d required %0d", grant_id, mdl_gid);
            if (busy !== 1'b0 || m_tvalid !== 1'b0 || s_tready !== '0 || m_tdata !== '0) errors++;
            if (grant_id !== PW'(mdl_gid)) errors++;
            e = s_tvalid & s_tstart;
            p = rr_pick(e, mdl_rr);
            if (p >= 0) begin
                mdl_lock = 1'b1;
                mdl_gid  = p;
            end
        end else begin
            g = mdl_gid;
            checks++;
            if (busy !== 1'b1 || grant_id !== PW'(g)) begin
                errors++;
                $display("FAIL lock_owner: busy=%b grant_id=%0d required busy=1 grant_id=%0d", busy, grant_id, g);
            end
            exp_rdy = '0;
            exp_rdy[g] = m_tready;
            checks++;
            if (m_tvalid !== s_tvalid[g] || s_tready !== exp_rdy) begin
                errors++;
                $display("FAIL handshake_mux: m_tvalid=%b s_tready=%b required m_tvalid=%b s_tready=%b",
                         m_tvalid, s_tready, s_tvalid[g], exp_rdy);
            end
            checks++;
            if (s_tvalid[g] ? (m_tdata !== s_tdata[g*TD +: TD] || m_tuser !== s_tuser[g*TU +: TU] ||
                               m_tkeep !== s_tkeep[g*TK +: TK] || m_tstart !== s_tstart[g] ||
                               m_tlast !== s_tlast[g])
                            : (m_tdata !== '0 || m_tuser !== '0 || m_tkeep !== '0 ||
                               m_tstart !== 1'b0 || m_tlast !== 1'b0)) begin
                errors++;
                $display("FAIL payload_mux: port %0d m_tdata[31:0]=%h required %h", g, m_tdata[31:0],
                         s_tvalid[g] ? s_tdata[g*TD +: 32] : 32'h0);
            end
            if (s_tvalid[g] && m_tready) begin
                fires++;
                fire_cyc.push_back(cyc);
                checks++;
                if (m_tdata[19:16] !== 4'(g) || m_tdata[15:0] !== 16'(out_seq[g])) begin
                    errors++;
                    $display("FAIL beat_order: got port %0d seq %0d required port %0d seq %0d",
                             m_tdata[19:16], m_tdata[15:0], g, out_seq[g]);
                end
                out_seq[g]++;
                if (m_tstart === 1'b1) obs_starts.push_back(int'(grant_id));
                if (s_tlast[g]) begin
                    mdl_lock = 1'b0;
                    mdl_rr   = (g + 1) % NP;
                end
            end
        end
        for (int i = 0; i < NP; i++) begin
            if (!nostart[i] && s_tvalid[i] && s_tready[i] && srcq[i].size() != 0) void'(srcq[i].pop_front());
        end
        cyc++;
    endtask

    task automatic step();
        @(negedge clk);
        drive_inputs();
        #1;
        evaluate();
    endtask

    task automatic run_until_done(int budget);
        int n = 0;
        while ((pending() || mdl_lock) && n < budget) begin
            step();
            n++;
        end
        checks++;
        if (pending() || mdl_lock) begin
            errors++;
            $display("FAIL timeout: traffic still pending after %0d cycles, required drained", budget);
        end
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL rst_m_tvalid: got %b required 0", m_tvalid); end
        checks++; if (s_tready !== '0)   begin errors++; $display("FAIL rst_s_tready: got %b required 0", s_tready); end
        checks++; if (m_tdata !== '0)    begin errors++; $display("FAIL rst_m_tdata: got %h required 0", m_tdata[31:0]); end
        checks++; if (grant_id !== '0)   begin errors++; $display("FAIL rst_grant_id: got %0d required 0", grant_id); end
        checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL rst_busy: got %b required 0", busy); end
        clear_logs();
        repeat (3) step();
    endtask

    task automatic test_single_port();
        do_reset();
        clear_logs();
        add_pkt(2, 3);
        run_until_done(20);
        step();
        checks++;
        if (fire_cyc.size() != 3 || fire_cyc[0] != 1 || fire_cyc[1] != 2 || fire_cyc[2] != 3) begin
            errors++;
            $display("FAIL single_timing: %0d beats, first at cycle %0d, required 3 beats at cycles 1..3",
                     fire_cyc.size(), fire_cyc.size() ? fire_cyc[0] : -1);
        end
        checks++;
        if (busy_hist.size() != 5 || busy_hist[0] != 1'b0 || busy_hist[4] != 1'b0) begin
            errors++;
            $display("FAIL single_bubble: cycles=%0d, required idle at cycles 0 and 4 of 5", busy_hist.size());
        end
        // rr_ptr must now sit at 3, so port 3 beats port 0
        clear_logs();
        add_pkt(0, 1);
        add_pkt(3, 1);
        run_until_done(20);
        checks++;
        if (obs_starts.size() != 2 || obs_starts[0] != 3 || obs_starts[1] != 0) begin
            errors++;
            $display("FAIL rr_after_port2: order %p required 3,0", obs_starts);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        clear_logs();
        add_pkt(0, 2); add_pkt(1, 2); add_pkt(3, 2);
        run_until_done(40);
        checks++;
        if (obs_starts.size() != 3 || obs_starts[0] != 0 || obs_starts[1] != 1 || obs_starts[2] != 3) begin
            errors++;
            $display("FAIL rr_order: order %p required 0,1,3", obs_starts);
        end
        checks++;
        if (cyc != 9 || fires != 6) begin
            errors++;
            $display("FAIL rr_bubbles: cycles=%0d beats=%0d required 9 cycles 6 beats", cyc, fires);
        end
    endtask

    task automatic test_backpressure();
        int bad = 0;
        clear_logs();
        add_pkt(1, 4);
        step();
        step();
        add_pkt(0, 2);
        tready_q.push_back(1'b0); tready_q.push_back(1'b0); tready_q.push_back(1'b1);
        for (int c = 0; c < 3; c++) begin
            step();
            if (s_tready[0] !== 1'b0 || s_tready[1] !== m_tready || busy !== 1'b1 || grant_id !== 2'd1) bad++;
        end
        checks++;
        if (bad != 0 || fires != 2) begin
            errors++;
            $display("FAIL bp_stall: bad cycles=%0d beats=%0d required 0 bad 2 beats", bad, fires);
        end
        run_until_done(30);
        checks++;
        if (obs_starts.size() != 2 || obs_starts[0] != 1 || obs_starts[1] != 0 || fires != 6) begin
            errors++;
            $display("FAIL bp_sequence: order %p beats=%0d required 1,0 with 6 beats", obs_starts, fires);
        end
        checks++;
        if (out_seq[0] != src_seq[0] || out_seq[1] != src_seq[1]) begin
            errors++;
            $display("FAIL bp_count: received %0d/%0d required %0d/%0d", out_seq[0], out_seq[1], src_seq[0], src_seq[1]);
        end
    endtask

    task automatic test_nostart_single_beat();
        int busy_cnt = 0;
        clear_logs();
        nostart[0] = 1'b1;
        add_pkt(2, 1);
        run_until_done(20);
        repeat (6) step();
        foreach (busy_hist[i]) if (busy_hist[i]) busy_cnt++;
        checks++;
        if (obs_starts.size() != 1 || obs_starts[0] != 2 || fires != 1) begin
            errors++;
            $display("FAIL single_beat: order %p beats=%0d required port 2 with 1 beat", obs_starts, fires);
        end
        checks++;
        if (busy_cnt != 1) begin
            errors++;
            $display("FAIL nostart_never_granted: busy cycles=%0d required 1", busy_cnt);
        end
        nostart[0] = 1'b0;
    endtask

    task automatic test_reset_mid_packet();
        int n = 0;
        do_reset();
        clear_logs();
        add_pkt(1, 4);
        while (fires < 1 && n < 20) begin
            step();
            n++;
        end
        @(negedge clk);
        drive_inputs();
        #1;
        checks++;
        if (m_tvalid !== 1'b1 || m_tdata[15:0] !== 16'd1) begin
            errors++;
            $display("FAIL mid_beat2: m_tvalid=%b seq=%0d required 1 and seq 1", m_tvalid, m_tdata[15:0]);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (m_tvalid !== 1'b0 || s_tready !== '0 || m_tdata !== '0 || busy !== 1'b0 || grant_id !== '0) begin
            errors++;
            $display("FAIL async_reset: m_tvalid=%b s_tready=%b busy=%b grant_id=%0d required all 0",
                     m_tvalid, s_tready, busy, grant_id);
        end
        do_reset();
        clear_logs();
        add_pkt(3, 2);
        run_until_done(20);
        checks++;
        if (obs_starts.size() != 1 || obs_starts[0] != 3 || fires != 2) begin
            errors++;
            $display("FAIL post_reset_grant: order %p beats=%0d required port 3 with 2 beats", obs_starts, fires);
        end
    endtask

    task automatic test_random();
        do_reset();
        hold_rand   = 1'b1;
        tready_rand = 1'b1;
        for (int batch = 0; batch < 8; batch++) begin
            clear_logs();
            for (int j = 0; j < 5; j++) add_pkt($urandom_range(0, NP-1), $urandom_range(1, 5));
            run_until_done(2000);
        end
        for (int i = 0; i < NP; i++) begin
            checks++;
            if (out_seq[i] != src_seq[i]) begin
                errors++;
                $display("FAIL random_drain: port %0d received %0d beats required %0d", i, out_seq[i], src_seq[i]);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_single_port();
        test_round_robin();
        test_backpressure();
        test_nostart_single_beat();
        test_reset_mid_packet();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required normal completion");
        $fatal(1, "watchdog");
    end

endmodule
